// File: rtl/case_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : case_conv_arbiter
//  Description : Two-requester ASCII toupper converter sharing one datapath.
//                Requesters are arbitrated round-robin at string granularity:
//                once a string starts it owns the datapath until its last
//                character is accepted. One-cycle latency output register
//                with ready/valid backpressure and per-requester counters of
//                converted letters.
//  Revision    : 1.0 - initial release
// ============================================================================
module case_conv_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [7:0]  s0_data,
    input  logic        s0_last,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [7:0]  s1_data,
    input  logic        s1_last,
    input  logic        conv_en,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_src,
    output logic        m_last,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    localparam logic [7:0] C_LOWER_A  = 8'h61;
    localparam logic [7:0] C_LOWER_Z  = 8'h7A;
    localparam logic [7:0] C_CASE_BIT = 8'h20;

    logic [1:0]  state_q, state_d;
    logic        rr_q, rr_d;
    logic        m_valid_q;
    logic [7:0]  m_data_q;
    logic        m_src_q;
    logic        m_last_q;
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    logic        w_gnt_en;
    logic        w_gnt_idx;
    logic        w_free;
    logic        w_accept;
    logic [7:0]  w_sel_data;
    logic        w_sel_last;
    logic        w_conv_hit;
    logic [7:0]  w_conv_data;

    // Grant selection: a locked string keeps ownership; IDLE picks the sole
    // valid requester, or the round-robin preferred one when both are valid.
    always_comb begin
        w_gnt_en  = 1'b0;
        w_gnt_idx = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s0_valid && s1_valid) begin
                    w_gnt_en  = 1'b1;
                    w_gnt_idx = rr_q;
                end else if (s0_valid) begin
                    w_gnt_en  = 1'b1;
                    w_gnt_idx = 1'b0;
                end else if (s1_valid) begin
                    w_gnt_en  = 1'b1;
                    w_gnt_idx = 1'b1;
                end
            end
            ST_LOCK0: begin
                w_gnt_en  = 1'b1;
                w_gnt_idx = 1'b0;
            end
            ST_LOCK1: begin
                w_gnt_en  = 1'b1;
                w_gnt_idx = 1'b1;
            end
            default: begin
                w_gnt_en  = 1'b0;
                w_gnt_idx = 1'b0;
            end
        endcase
    end

    // Handshake, operand mux and toupper conversion of the granted beat.
    // Ready is suppressed during reset so nothing is accepted in that cycle.
    always_comb begin
        w_free      = !m_valid_q || m_ready;
        s0_ready    = !rst && w_gnt_en && !w_gnt_idx && w_free;
        s1_ready    = !rst && w_gnt_en &&  w_gnt_idx && w_free;
        w_accept    = (s0_ready && s0_valid) || (s1_ready && s1_valid);
        w_sel_data  = w_gnt_idx ? s1_data : s0_data;
        w_sel_last  = w_gnt_idx ? s1_last : s0_last;
        w_conv_hit  = conv_en && (w_sel_data >= C_LOWER_A) && (w_sel_data <= C_LOWER_Z);
        w_conv_data = w_conv_hit ? (w_sel_data & ~C_CASE_BIT) : w_sel_data;
    end

    // Lock/round-robin update: a last beat releases the lock and hands
    // preference to the other requester; otherwise the string stays locked.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        if (w_accept) begin
            if (w_sel_last) begin
                state_d = ST_IDLE;
                rr_d    = ~w_gnt_idx;
            end else begin
                state_d = w_gnt_idx ? ST_LOCK1 : ST_LOCK0;
            end
        end
    end

    // State, output register and counters; output holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_src_q   <= 1'b0;
            m_last_q  <= 1'b0;
            cnt0_q    <= 16'h0000;
            cnt1_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            if (w_accept) begin
                m_valid_q <= 1'b1;
                m_data_q  <= w_conv_data;
                m_src_q   <= w_gnt_idx;
                m_last_q  <= w_sel_last;
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
            if (w_accept && w_conv_hit && !w_gnt_idx) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (w_accept && w_conv_hit && w_gnt_idx) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_src   = m_src_q;
    assign m_last  = m_last_q;
    assign cnt0    = cnt0_q;
    assign cnt1    = cnt1_q;

endmodule
`default_nettype wire

// File: tb/tb_case_conv_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_case_conv_arbiter
//  Description : Directed self-checking bench for case_conv_arbiter.
//                Inputs change 1ns after the rising edge; outputs and
//                combinational readies are sampled at that same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_case_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s0_last;
    logic [7:0]  s0_data;
    logic        s1_valid, s1_ready, s1_last;
    logic [7:0]  s1_data;
    logic        conv_en;
    logic        m_valid, m_ready, m_src, m_last;
    logic [7:0]  m_data;
    logic [15:0] cnt0, cnt1;

    int n_vec = 0;
    int n_err = 0;

    case_conv_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_data  (s0_data),
        .s0_last  (s0_last),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_data  (s1_data),
        .s1_last  (s1_last),
        .conv_en  (conv_en),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_last   (m_last),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
        s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        conv_en = 1'b1;
        m_ready = 1'b1;
        rst     = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({m_valid, m_data, m_src, m_last} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_out: got v=%b d=%h s=%b l=%b, want all 0", m_valid, m_data, m_src, m_last);
        end
        n_vec++;
        if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
            n_err++;
            $display("FAIL reset_cnt: got %h/%h, want 0000/0000", cnt0, cnt1);
        end
        s0_valid = 1'b1; s1_valid = 1'b1;
        #1;
        n_vec++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b%b, want 00", s0_ready, s1_ready);
        end
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        s0_valid = 1'b1; s0_data = 8'h61; s0_last = 1'b1;
        conv_en = 1'b1; m_ready = 1'b1;
        #1;
        n_vec++;
        if (s0_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_ready: got %b, want 1", s0_ready);
        end
        tick();
        idle_inputs();
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 8'h41 || m_src !== 1'b0 || m_last !== 1'b1) begin
            n_err++;
            $display("FAIL single_out: got v=%b d=%h s=%b l=%b, want v=1 d=41 s=0 l=1", m_valid, m_data, m_src, m_last);
        end
        n_vec++;
        if (cnt0 !== 16'd1) begin
            n_err++;
            $display("FAIL single_cnt0: got %h, want 0001", cnt0);
        end
        tick();
        n_vec++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_vclear: got %b, want 0", m_valid);
        end
    endtask

    task automatic test_passthru();
        logic [7:0] din  [4] = '{8'h60, 8'h7B, 8'h7A, 8'h5A};
        logic [7:0] dexp [4] = '{8'h60, 8'h7B, 8'h5A, 8'h5A};
        conv_en = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s1_valid = 1'b1; s1_data = din[i]; s1_last = (i == 3);
            tick();
            n_vec++;
            if (m_valid !== 1'b1 || m_data !== dexp[i] || m_src !== 1'b1 || m_last !== (i == 3)) begin
                n_err++;
                $display("FAIL pass_beat%0d: got v=%b d=%h s=%b l=%b, want v=1 d=%h s=1 l=%b",
                         i, m_valid, m_data, m_src, m_last, dexp[i], (i == 3));
            end
        end
        idle_inputs();
        n_vec++;
        if (cnt1 !== 16'd1) begin
            n_err++;
            $display("FAIL pass_cnt1: got %h, want 0001", cnt1);
        end
        conv_en = 1'b0;
        s1_valid = 1'b1; s1_data = 8'h61; s1_last = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (m_data !== 8'h61 || m_src !== 1'b1 || cnt1 !== 16'd1 || cnt0 !== 16'd1) begin
            n_err++;
            $display("FAIL pass_noconv: got d=%h s=%b c0=%h c1=%h, want d=61 s=1 c0=0001 c1=0001",
                     m_data, m_src, cnt0, cnt1);
        end
        conv_en = 1'b1;
        tick();
    endtask

    task automatic test_arbitration();
        logic [7:0] str0 [2] = '{8'h61, 8'h62};
        logic [7:0] str1 [2] = '{8'h63, 8'h64};
        logic       exp_src  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp_dat  [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
        logic       exp_last [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int i0 = 0;
        int i1 = 0;
        logic r0, r1;
        do_reset();
        conv_en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s0_valid = (i0 < 2); s0_data = str0[i0 % 2]; s0_last = (i0 == 1);
            s1_valid = (i1 < 2); s1_data = str1[i1 % 2]; s1_last = (i1 == 1);
            #1;
            r0 = s0_ready; r1 = s1_ready;
            n_vec++;
            if ({r0, r1} !== {!exp_src[k], exp_src[k]}) begin
                n_err++;
                $display("FAIL arb_grant%0d: got ready=%b%b, want %b%b", k, r0, r1, !exp_src[k], exp_src[k]);
            end
            tick();
            if (r0) i0++;
            if (r1) i1++;
            n_vec++;
            if (m_valid !== 1'b1 || m_src !== exp_src[k] || m_data !== exp_dat[k] || m_last !== exp_last[k]) begin
                n_err++;
                $display("FAIL arb_beat%0d: got v=%b s=%b d=%h l=%b, want v=1 s=%b d=%h l=%b",
                         k, m_valid, m_src, m_data, m_last, exp_src[k], exp_dat[k], exp_last[k]);
            end
        end
        s0_valid = 1'b1; s0_data = 8'h78; s0_last = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h79; s1_last = 1'b1;
        #1;
        n_vec++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL arb_rr_back: got ready=%b%b, want 10", s0_ready, s1_ready);
        end
        tick();
        idle_inputs();
        n_vec++;
        if (m_src !== 1'b0 || m_data !== 8'h58) begin
            n_err++;
            $display("FAIL arb_rr_beat: got s=%b d=%h, want s=0 d=58", m_src, m_data);
        end
        tick();
    endtask

    task automatic test_backpressure();
        conv_en = 1'b1; m_ready = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h61; s0_last = 1'b0;
        tick();
        s0_data = 8'h62;
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            if (s0_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 8'h41 || m_last !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h l=%b, want rdy=0 v=1 d=41 l=0",
                         k, s0_ready, m_valid, m_data, m_last);
            end
            tick();
        end
        m_ready = 1'b1;
        #1;
        n_vec++;
        if (s0_ready !== 1'b1 || m_data !== 8'h41) begin
            n_err++;
            $display("FAIL bp_release: got rdy=%b d=%h, want rdy=1 d=41", s0_ready, m_data);
        end
        tick();
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 8'h42) begin
            n_err++;
            $display("FAIL bp_next: got v=%b d=%h, want v=1 d=42", m_valid, m_data);
        end
        s0_data = 8'h63; s0_last = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 8'h43 || m_last !== 1'b1) begin
            n_err++;
            $display("FAIL bp_last: got v=%b d=%h l=%b, want v=1 d=43 l=1", m_valid, m_data, m_last);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        conv_en = 1'b1; m_ready = 1'b1;
        s1_valid = 1'b1; s1_data = 8'h61; s1_last = 1'b0;
        tick();
        m_ready = 1'b0;
        s1_data = 8'h62;
        s0_valid = 1'b1; s0_data = 8'h63; s0_last = 1'b1;
        tick();
        n_vec++;
        if (m_valid !== 1'b1 || m_src !== 1'b1 || cnt1 !== 16'd1) begin
            n_err++;
            $display("FAIL rstmid_pre: got v=%b s=%b c1=%h, want v=1 s=1 c1=0001", m_valid, m_src, cnt1);
        end
        rst = 1'b1;
        m_ready = 1'b1;
        #1;
        n_vec++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ready: got %b%b, want 00", s0_ready, s1_ready);
        end
        tick();
        rst = 1'b0;
        n_vec++;
        if ({m_valid, m_data, m_src, m_last} !== 11'd0 || cnt0 !== 16'h0 || cnt1 !== 16'h0) begin
            n_err++;
            $display("FAIL rstmid_out: got v=%b d=%h s=%b l=%b c0=%h c1=%h, want all 0",
                     m_valid, m_data, m_src, m_last, cnt0, cnt1);
        end
        s1_data = 8'h64; s1_last = 1'b1;
        #1;
        n_vec++;
        if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_grant: got ready=%b%b, want 10", s0_ready, s1_ready);
        end
        tick();
        idle_inputs();
        n_vec++;
        if (m_valid !== 1'b1 || m_src !== 1'b0 || m_data !== 8'h43) begin
            n_err++;
            $display("FAIL rstmid_beat: got v=%b s=%b d=%h, want v=1 s=0 d=43", m_valid, m_src, m_data);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        conv_en = 1'b1; m_ready = 1'b1;
        s0_valid = 1'b1; s0_data = 8'h7A; s0_last = 1'b1;
        repeat (65535) tick();
        n_vec++;
        if (cnt0 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL wrap_max: got %h, want ffff", cnt0);
        end
        tick();
        idle_inputs();
        n_vec++;
        if (cnt0 !== 16'h0000 || cnt1 !== 16'h0000 || m_data !== 8'h5A) begin
            n_err++;
            $display("FAIL wrap_zero: got c0=%h c1=%h d=%h, want c0=0000 c1=0000 d=5a", cnt0, cnt1, m_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        conv_en = 1'b0;
        m_ready = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_single();
        test_passthru();
        test_arbitration();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/case_conv_arbiter.md
CASE_CONV_ARBITER -- requirements
Module: case_conv_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 s0_valid  input  1  requester 0 character valid.
REQ-004 s0_ready  output  1  requester 0 character accepted this cycle when high with s0_valid.
REQ-005 s0_data  input  8  requester 0 ASCII character, bit 7 MSB.
REQ-006 s0_last  input  1  requester 0 final character of string.
REQ-007 s1_valid, s1_ready, s1_data, s1_last  same directions, widths and meaning as REQ-003..006, for requester 1.
REQ-008 conv_en  input  1  1 = apply toupper, 0 = pass-through.
REQ-009 m_valid  output  1  converted character valid.
REQ-010 m_ready  input  1  downstream accepts m_data.
REQ-011 m_data  output  8  converted character.
REQ-012 m_src  output  1  requester index of m_data.
REQ-013 m_last  output  1  copy of accepted s*_last.
REQ-014 cnt0, cnt1  output  16  per-requester count of letters converted.

Function
REQ-015 The block SHALL share one toupper datapath between two requesters, with string-granular round-robin arbitration.
REQ-016 FSM states SHALL be IDLE, LOCK0, LOCK1; rr pointer (1 bit) holds the preferred requester.
REQ-017 free = !m_valid || m_ready; sX_ready SHALL be high only when requester X is granted and free is high.
REQ-018 IDLE grant: only one valid -> that one; both valid -> requester rr; none -> no grant.
REQ-019 LOCKX grant: requester X only, regardless of the other valid.
REQ-020 On accepted beat from X with last=0: next state LOCKX.
REQ-021 On accepted beat from X with last=1: next state IDLE, rr <= ~X.
REQ-022 No accepted beat: state and rr unchanged.
REQ-023 Conversion: if conv_en=1 and data in 0x61..0x7A, output = data with bit 5 cleared (data - 0x20); otherwise data unchanged; conv_en sampled in accept cycle.
REQ-024 Latency SHALL be 1 cycle: accepted beat appears on m_data/m_src/m_last with m_valid=1 the following cycle.
REQ-025 m_valid and m_data/m_src/m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 Back-to-back: with m_ready=1 continuously, one beat per cycle SHALL be sustained.
REQ-027 cntX SHALL increment by 1 per accepted beat from X whose data was modified by REQ-023; wraps 0xFFFF -> 0x0000.
REQ-028 A waiting requester SHALL be stalled (ready=0) until the locked string's last beat is accepted; no data loss or duplication.
REQ-029 m_valid SHALL clear the cycle after m_ready=1 with no new acceptance.

Reset
REQ-030 rst=1 SHALL force state IDLE, rr=0, m_valid=0, m_data=0x00, m_src=0, m_last=0, cnt0=cnt1=0, s0_ready=s1_ready=0 combinationally while rst=1.
REQ-031 rst mid-string SHALL abandon the string: lock released, in-flight m_valid beat dropped, no beat accepted in the reset cycle.
REQ-032 rst SHALL take priority over all simultaneous events.

Verification
REQ-033 Single beat: s0 0x61 last=1, conv_en=1, m_ready=1 -> next cycle m_valid=1, m_data=0x41, m_src=0, m_last=1; cnt0=1.
REQ-034 Pass-through/boundaries: s1 sends 0x60,0x7B,0x7A,0x5A conv_en=1 -> 0x60,0x7B,0x5A,0x5A; cnt1=1; conv_en=0 with 0x61 -> 0x61, cnt unchanged.
REQ-035 Arbitration: both valid from reset, 2-char strings each -> s0 string (2 beats) then s1 string, no interleave; then rr=0 again.
REQ-036 Backpressure: m_ready=0 for 3 cycles mid-string -> m_data held stable, sX_ready=0, no beat lost once m_ready=1.
REQ-037 Reset mid-string: rst during LOCK1 with m_valid=1 -> next cycle all outputs 0, IDLE; s0 served first afterwards.
REQ-038 Counter wrap: preload via 65536 converted beats on s0 -> cnt0 returns to 0x0000.
